count_sequencer: RTL and testbench

Run controller for the 8-bit up/down counter and seven-segment display path. Converts asynchronous start/stop buttons into clean single-cycle events and sequences the counter's load, direction and enable inputs through a load/run/pause/done state machine. Generates the count-rate tick from clk_50M with a prescaler, so the counter runs on clk_50M with an enable instead of a divided clock. Stops the run when the counter value fed back from the datapath equals a programmed limit.

---
 rtl/count_sequencer.sv | 133 +++++++++++++
 tb/tb_count_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Run controller for the up/down counter: button conditioning, prescaled tick and load/run/pause/done FSM.
// Define AUTO_RELOAD_EN to restart a run automatically one cycle after reaching DONE.
module count_sequencer_btn (
  input  logic clk_50M,
  input  logic rst,
  input  logic i_btn,
  output logic o_event
);
  logic       r_s1, r_s2, r_d, r_armed;
  logic [1:0] r_warm;

  // r_armed requires a low level after the synchronizer is primed, so a button
  // held through reset does not count as a fresh press.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_d     <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_d    <= r_s2;
      r_warm <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_s2) r_armed <= 1'b1;
    end
  end

  assign o_event = r_s2 & ~r_d & r_armed;
endmodule

module count_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int WIDTH    = 8
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             cnt_updn,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [PW-1:0]    r_pre, w_pre_next;
  logic             r_mode, r_first;
  logic [WIDTH-1:0] r_limit;
  logic             w_start, w_stop;

  count_sequencer_btn u_start (.clk_50M(clk_50M), .rst(rst), .i_btn(start_btn), .o_event(w_start));
  count_sequencer_btn u_stop  (.clk_50M(clk_50M), .rst(rst), .i_btn(stop_btn),  .o_event(w_stop));

  // Stop has priority over start in every state.
  always_comb begin
    w_next     = r_state;
    w_pre_next = r_pre;
    case (r_state)
      S_IDLE:  if (!w_stop && w_start) w_next = S_LOAD;
      S_LOAD: begin
        w_next     = S_RUN;
        w_pre_next = '0;
      end
      S_RUN: begin
        w_pre_next = (r_pre == TERM) ? '0 : r_pre + 1'b1;
        if (w_stop)                                w_next = S_PAUSE;
        else if (!r_first && count_in == r_limit) w_next = S_DONE;
      end
      S_PAUSE: begin
        if (w_stop)       w_next = S_IDLE;
        else if (w_start) w_next = S_RUN;
      end
      S_DONE: begin
        if (w_stop)                w_next = S_IDLE;
        else if (AUTO || w_start)  w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_mode     <= 1'b0;
      r_limit    <= '0;
      r_first    <= 1'b0;
      cnt_load   <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_updn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pre   <= w_pre_next;
      r_first <= (r_state == S_LOAD);
      if (w_next == S_LOAD && !(AUTO && r_state == S_DONE)) begin
        r_mode  <= mode;
        r_limit <= limit;
      end
      cnt_load   <= (w_next == S_LOAD);
      cnt_enable <= (w_next == S_LOAD) || (w_next == S_RUN && w_pre_next == TERM);
      cnt_updn   <= (w_next == S_RUN || w_next == S_PAUSE) ? r_mode : 1'b0;
      busy       <= (w_next == S_LOAD || w_next == S_RUN || w_next == S_PAUSE);
      done       <= (w_next == S_DONE);
    end
  end

  assign state = r_state;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK_DIV=4 and a behavioural counter datapath.
module tb_count_sequencer;
  localparam int TD = 4;
  localparam int W  = 8;

  logic         clk_50M = 1'b0;
  logic         rst = 1'b1, start_btn = 1'b0, stop_btn = 1'b0, mode = 1'b0;
  logic [W-1:0] limit = '0, count_in;
  logic         cnt_load, cnt_enable, cnt_updn, busy, done;
  logic [2:0]   state;

  logic [W-1:0] preset = '0, model_cnt = '0;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_ticks = 0, n_loads = 0, last_tick_cyc = 0, load_cyc = 0;
  int t0, l0;

  count_sequencer #(.TICK_DIV(TD), .WIDTH(W)) dut (
    .clk_50M(clk_50M), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .mode(mode), .limit(limit), .count_in(count_in), .cnt_load(cnt_load),
    .cnt_enable(cnt_enable), .cnt_updn(cnt_updn), .busy(busy), .done(done), .state(state)
  );

  always #5 clk_50M = ~clk_50M;

  // Datapath counter model: load has priority over enable.
  assign count_in = model_cnt;
  always @(posedge clk_50M) begin
    cyc <= cyc + 1;
    if (cnt_load) begin
      model_cnt <= preset;
      n_loads   <= n_loads + 1;
      load_cyc  <= cyc;
    end else if (cnt_enable) begin
      model_cnt     <= cnt_updn ? model_cnt + 8'd1 : model_cnt - 8'd1;
      n_ticks       <= n_ticks + 1;
      last_tick_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic press(input logic s, input logic p);
    start_btn = s;
    stop_btn  = p;
    @(negedge clk_50M);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k = 0;
    while (state !== s && k < budget) begin
      @(negedge clk_50M);
      k++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic run_setup(input logic m, input logic [7:0] p, input logic [7:0] lim);
    mode = m; preset = p; limit = lim;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick_n(3);
    check("reset_outs", 32'({state, cnt_load, cnt_enable, cnt_updn, busy, done}), 0);
    rst = 1'b0;
    tick_n(5);

    // Up run 5 -> 8; mode/limit changed after LOAD must be ignored.
    run_setup(1'b1, 8'h05, 8'h08);
    t0 = n_ticks;
    press(1'b1, 1'b0);
    tick_n(1);
    check("btn_latency_idle", 32'(state), 0);
    tick_n(1);
    check("load_state", 32'(state), 1);
    check("load_outs", 32'({cnt_load, cnt_enable, busy, done}), 32'b1110);
    mode = 1'b0; limit = 8'h00;
    tick_n(1);
    check("run_state", 32'(state), 2);
    check("run_outs", 32'({cnt_load, cnt_enable, cnt_updn}), 32'b001);
    wait_state("up_done", 3'd4, 40);
    check("up_ticks", 32'(n_ticks - t0), 3);
    check("up_cnt", 32'(model_cnt), 8'h08);
    check("up_tick_timing", 32'(last_tick_cyc - load_cyc), 3 * TD);
    check("up_done_outs", 32'({busy, done}), 32'b01);
`ifndef AUTO_RELOAD_EN
    tick_n(1000);
    check("done_persist", 32'(state), 4);
    check("done_no_ticks", 32'(n_ticks - t0), 3);
    press(1'b0, 1'b1);
    tick_n(2);
    check("done_stop_idle", 32'(state), 0);
`else
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tick_n(4);
`endif

    // Pause 2 cycles after a tick, resume, then abort.
    run_setup(1'b1, 8'h00, 8'hFF);
    press(1'b1, 1'b0);
    wait_state("p_run", 3'd2, 10);
    for (int k = 0; k < 20 && !cnt_enable; k++) @(negedge clk_50M);
    check("p_tick", 32'(cnt_enable), 1);
    press(1'b0, 1'b1);
    tick_n(1);
    check("p_still_run", 32'(state), 2);
    tick_n(1);
    check("p_pause", 32'({state, busy, cnt_enable}), 32'b01110);
    t0 = n_ticks;
    tick_n(10);
    check("p_no_ticks", 32'(n_ticks - t0), 0);
    press(1'b1, 1'b0);
    tick_n(2);
    check("p_resume", 32'({state, cnt_enable}), 32'b0100);
    tick_n(1);
    check("p_resume_tick", 32'(cnt_enable), 1);
    press(1'b0, 1'b1);
    tick_n(2);
    check("p_pause2", 32'(state), 3);
    press(1'b0, 1'b1);
    tick_n(2);
    check("p_abort", 32'({state, busy, cnt_updn}), 0);

    // Simultaneous start+stop: RUN -> PAUSE, then PAUSE -> IDLE.
    press(1'b1, 1'b0);
    tick_n(5);
    check("sim_run", 32'(state), 2);
    press(1'b1, 1'b1);
    tick_n(2);
    check("sim_pause", 32'(state), 3);
    press(1'b1, 1'b1);
    tick_n(2);
    check("sim_idle", 32'(state), 0);

    // Down run wrapping 0x01 -> 0x00 -> 0xFF.
    run_setup(1'b0, 8'h01, 8'hFF);
    t0 = n_ticks;
    press(1'b1, 1'b0);
    for (int k = 0; k < 20 && n_ticks == t0; k++) @(negedge clk_50M);
    check("wrap_first", 32'(model_cnt), 8'h00);
    wait_state("wrap_done", 3'd4, 40);
    check("wrap_ticks", 32'(n_ticks - t0), 2);
    check("wrap_cnt", 32'(model_cnt), 8'hFF);
    press(1'b0, 1'b1);
    tick_n(2);

    // preset == limit: masked first RUN cycle, DONE in the second, no tick.
    run_setup(1'b1, 8'h07, 8'h07);
    t0 = n_ticks;
    press(1'b1, 1'b0);
    tick_n(3);
    check("eq_run1", 32'(state), 2);
    tick_n(1);
    check("eq_run2", 32'(state), 2);
    tick_n(1);
    check("eq_done", 32'(state), 4);
    check("eq_ticks", 32'(n_ticks - t0), 0);
    press(1'b0, 1'b1);
    tick_n(2);

`ifndef AUTO_RELOAD_EN
    // Held start gives one event only.
    run_setup(1'b1, 8'h00, 8'h02);
    l0 = n_loads;
    start_btn = 1'b1;
    tick_n(100);
    start_btn = 1'b0;
    check("held_loads", 32'(n_loads - l0), 1);
    check("held_done", 32'(state), 4);
    press(1'b0, 1'b1);
    tick_n(2);
`else
    // Auto reload: DONE for one cycle then LOAD, three times.
    run_setup(1'b1, 8'h05, 8'h08);
    l0 = n_loads;
    press(1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      wait_state("auto_done", 3'd4, 40);
      tick_n(1);
      check("auto_load", 32'(state), 1);
    end
    tick_n(1);
    check("auto_loads", 32'(n_loads - l0), 4);
    press(1'b0, 1'b1);
    tick_n(2);
    check("auto_stop_pause", 32'(state), 3);
    press(1'b0, 1'b1);
    tick_n(2);
`endif
    check("idle_before_rst", 32'(state), 0);

    // Asynchronous reset mid-run, start held through release.
    run_setup(1'b1, 8'h00, 8'hFF);
    press(1'b1, 1'b0);
    tick_n(6);
    #2;
    rst = 1'b1;
    start_btn = 1'b1;
    #1;
    check("rst_async", 32'({state, cnt_load, cnt_enable, cnt_updn, busy, done}), 0);
    l0 = n_loads;
    @(negedge clk_50M);
    rst = 1'b0;
    tick_n(20);
    check("held_thru_rst", 32'({state, busy}), 0);
    check("held_thru_rst_ld", 32'(n_loads - l0), 0);
    start_btn = 1'b0;
    tick_n(3);
    press(1'b1, 1'b0);
    tick_n(2);
    check("post_rst_start", 32'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
